fpu_pipe_scoreboard: RTL

Parametrised issue-control and result-tracking block for the floating-point pipeline. It generalises the fixed five-stage FPU control path, whose per-stage shift registers, hard-wired hazard checks and forwarding checks assume fixed per-unit latencies. Here pipeline depth and register count are parameters, and each issued op carries its own result latency. The block sits between decode and the FPU datapath and produces four things: issue stall, per-operand forwarding stage selects, the single write-back port control, and a per-register pending mask.

---
 rtl/fpu_pipe_scoreboard_if.sv | 41 ++++
 rtl/fpu_pipe_scoreboard.sv | 137 +++++++++++++
 2 files changed

// File: rtl/fpu_pipe_scoreboard_if.sv
// Issue bus from decode and status/control returned by the FPU scoreboard.
interface fpu_pipe_scoreboard_if #(
    parameter int DEPTH = 5,
    parameter int NREG  = 32,
    parameter int RAW   = 5,
    parameter int LW    = 3
);
    logic            iss_valid;
    logic            iss_legal;
    logic            iss_wr;
    logic [RAW-1:0]  iss_rd;
    logic [RAW-1:0]  iss_rs1;
    logic [RAW-1:0]  iss_rs2;
    logic            iss_use1;
    logic            iss_use2;
    logic [LW-1:0]   iss_lat;
    logic            flush;
    logic            stall;
    logic [LW-1:0]   fwd1_sel;
    logic [LW-1:0]   fwd2_sel;
    logic            wb_valid;
    logic [RAW-1:0]  wb_rd;
    logic [NREG-1:0] pending;
    logic [LW-1:0]   occupancy;

    modport master (
        output iss_valid, iss_legal, iss_wr, iss_rd,
        output iss_rs1, iss_rs2, iss_use1, iss_use2,
        output iss_lat, flush,
        input  stall, fwd1_sel, fwd2_sel,
        input  wb_valid, wb_rd, pending, occupancy
    );

    modport slave (
        input  iss_valid, iss_legal, iss_wr, iss_rd,
        input  iss_rs1, iss_rs2, iss_use1, iss_use2,
        input  iss_lat, flush,
        output stall, fwd1_sel, fwd2_sel,
        output wb_valid, wb_rd, pending, occupancy
    );
endinterface

// File: rtl/fpu_pipe_scoreboard.sv
// FPU issue scoreboard: per-op latency tracking, RAW stall,
// operand forwarding selects, write-back port and pending mask.
module fpu_pipe_scoreboard #(
    parameter int DEPTH = 5,
    parameter int NREG  = 32,
    parameter int RAW   = 5,
    parameter int LW    = 3
) (
    input logic                 clk,
    input logic                 rst_n,
    fpu_pipe_scoreboard_if.slave sb
);

    typedef struct packed {
        logic           v;
        logic           wr;
        logic [RAW-1:0] rd;
        logic [LW-1:0]  lat;
    } ent_t;

    ent_t st_q [1:DEPTH];
    ent_t st_d [1:DEPTH];

    logic [RAW-1:0] rs1_q, rs1_d;
    logic [RAW-1:0] rs2_q, rs2_d;
    logic           use1_q, use1_d;
    logic           use2_q, use2_d;

    logic            accept;
    logic            haz1, haz2;
    logic            stall_c;
    logic [LW-1:0]   lat_c;
    logic [LW-1:0]   fwd1_c, fwd2_c;
    logic [NREG-1:0] pend_c;
    logic [LW-1:0]   occ_c;

    always_comb begin
        lat_c = sb.iss_lat;
        if (sb.iss_lat == '0)
            lat_c = LW'(1);
        else if (sb.iss_lat > LW'(DEPTH))
            lat_c = LW'(DEPTH);
    end

    // Scan oldest to youngest so the youngest producer decides.
    always_comb begin
        haz1 = 1'b0;
        haz2 = 1'b0;
        for (int j = DEPTH; j >= 1; j--) begin
            if (st_q[j].v && st_q[j].wr) begin
                if (sb.iss_use1 && st_q[j].rd == sb.iss_rs1)
                    haz1 = (j + 1 < int'(st_q[j].lat));
                if (sb.iss_use2 && st_q[j].rd == sb.iss_rs2)
                    haz2 = (j + 1 < int'(st_q[j].lat));
            end
        end
    end

    assign stall_c = sb.iss_valid & sb.iss_legal & (haz1 | haz2);
    assign accept  = sb.iss_valid & ~stall_c;

    always_comb begin
        fwd1_c = '0;
        fwd2_c = '0;
        for (int k = DEPTH; k >= 2; k--) begin
            if (st_q[k].v && st_q[k].wr) begin
                if (use1_q && st_q[k].rd == rs1_q)
                    fwd1_c = LW'(k);
                if (use2_q && st_q[k].rd == rs2_q)
                    fwd2_c = LW'(k);
            end
        end
    end

    // Flush kills the issuing op and the two youngest in-flight entries.
    always_comb begin
        st_d[1] = '0;
        rs1_d   = '0;
        rs2_d   = '0;
        use1_d  = 1'b0;
        use2_d  = 1'b0;
        if (accept && !sb.flush) begin
            st_d[1].v   = sb.iss_legal;
            st_d[1].wr  = sb.iss_wr & sb.iss_legal;
            st_d[1].rd  = sb.iss_rd;
            st_d[1].lat = lat_c;
            if (sb.iss_legal) begin
                rs1_d  = sb.iss_rs1;
                rs2_d  = sb.iss_rs2;
                use1_d = sb.iss_use1;
                use2_d = sb.iss_use2;
            end
        end
        for (int k = 2; k <= DEPTH; k++) begin
            st_d[k] = st_q[k-1];
            if (sb.flush && k <= 3)
                st_d[k] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= DEPTH; k++)
                st_q[k] <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            use1_q <= 1'b0;
            use2_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            rs1_q  <= rs1_d;
            rs2_q  <= rs2_d;
            use1_q <= use1_d;
            use2_q <= use2_d;
        end
    end

    always_comb begin
        pend_c = '0;
        occ_c  = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (st_q[k].v)
                occ_c = occ_c + LW'(1);
            if (st_q[k].v && st_q[k].wr)
                pend_c[st_q[k].rd] = 1'b1;
        end
    end

    assign sb.stall     = stall_c;
    assign sb.fwd1_sel  = fwd1_c;
    assign sb.fwd2_sel  = fwd2_c;
    assign sb.wb_valid  = st_q[DEPTH].v & st_q[DEPTH].wr;
    assign sb.wb_rd     = sb.wb_valid ? st_q[DEPTH].rd : '0;
    assign sb.pending   = pend_c;
    assign sb.occupancy = occ_c;

endmodule
